// File: rtl/tdm_demux_8.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_8
// Description : Serial TDM demultiplexer. Assembles 8 framed slot bits into a
//               parallel byte and tracks framing errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_8 #(
    parameter int SYNC_EVERY = 1,
    parameter int ERR_W      = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             D,
    input  logic             SYNC,
    output logic [7:0]       O,
    output logic             VALID,
    output logic [2:0]       SLOT,
    output logic             LOCK,
    output logic             ERR,
    output logic [ERR_W-1:0] ERR_CNT
);

    localparam logic [0:0] c_HUNT     = 1'b0;
    localparam logic [0:0] c_LOCKED   = 1'b1;
    localparam logic       c_SYNC_REQ = (SYNC_EVERY != 0);

    logic [0:0]       r_state,   w_state;
    logic [2:0]       r_slot,    w_slot;
    logic [7:0]       r_asm,     w_asm;
    logic [7:0]       r_o,       w_o;
    logic             r_valid,   w_valid;
    logic             r_err,     w_err;
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt;
    logic [ERR_W-1:0] w_cnt_inc;

    // Saturating increment: holds at all-ones.
    assign w_cnt_inc = (&r_err_cnt) ? r_err_cnt : r_err_cnt + ERR_W'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= c_HUNT;
            r_slot    <= 3'd0;
            r_asm     <= 8'd0;
            r_o       <= 8'd0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state;
            r_slot    <= w_slot;
            r_asm     <= w_asm;
            r_o       <= w_o;
            r_valid   <= w_valid;
            r_err     <= w_err;
            r_err_cnt <= w_err_cnt;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_slot    = r_slot;
        w_asm     = r_asm;
        w_o       = r_o;
        w_valid   = 1'b0;
        w_err     = 1'b0;
        w_err_cnt = r_err_cnt;

        if (EN) begin
            case (r_state)
                c_HUNT: begin
                    if (SYNC) begin
                        w_asm[0] = D;
                        w_slot   = 3'd1;
                        w_state  = c_LOCKED;
                    end
                end
                default: begin
                    if (SYNC && (r_slot != 3'd0)) begin
                        // Realign: the sync bit starts a fresh frame.
                        w_err     = 1'b1;
                        w_err_cnt = w_cnt_inc;
                        w_asm[0]  = D;
                        w_slot    = 3'd1;
                    end else if (c_SYNC_REQ && !SYNC && (r_slot == 3'd0)) begin
                        w_err     = 1'b1;
                        w_err_cnt = w_cnt_inc;
                        w_slot    = 3'd0;
                        w_state   = c_HUNT;
                    end else begin
                        w_asm[r_slot] = D;
                        w_slot        = r_slot + 3'd1;
                        if (r_slot == 3'd7) begin
                            w_o     = {D, r_asm[6:0]};
                            w_valid = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign O       = r_o;
    assign VALID   = r_valid;
    assign SLOT    = r_slot;
    assign LOCK    = (r_state == c_LOCKED);
    assign ERR     = r_err;
    assign ERR_CNT = r_err_cnt;

endmodule
`default_nettype wire
